// File: rtl/main_memory.sv
// Two-bank (instruction/data) 13-bit word memory with a fixed-latency request handshake.
// One request is in flight at a time. Done pulses for one cycle when that request completes.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting; a read or write request is latched on the next edge
//   S_BUSY | latency counter running; the commit happens on the edge leaving
//   S_DONE | one-cycle completion; Done high, new requests ignored
module main_memory #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] address,
  input  logic [12:0] dataIn,
  output logic [12:0] dataOut,
  input  logic        write,
  input  logic        read,
  input  logic        instruction,
  output logic        Done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_op_wr;
  logic            r_bank_ins;
  logic [AW-1:0]   r_idx;
  logic [12:0]     r_data;
  logic [12:0]     r_mem_ins [DEPTH];
  logic [12:0]     r_mem_dat [DEPTH];

  logic            w_accept;
  logic            w_expire;
  logic            w_commit_wr;
  logic            w_commit_rd;
  logic            w_unused;

  // Upper address bits carry no meaning for this memory.
  assign w_unused = ^address[12:AW];

  assign w_accept = (r_state == S_IDLE) && (read || write);
  assign w_expire = (r_state == S_BUSY) && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (read || write) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == '0)   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Done        = (r_state == S_DONE);
    w_commit_wr = w_expire && r_op_wr;
    w_commit_rd = w_expire && !r_op_wr;
  end

  // Request latch and latency down-counter; write wins when both are requested.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_op_wr    <= 1'b0;
      r_bank_ins <= 1'b0;
      r_idx      <= '0;
      r_data     <= '0;
    end else if (w_accept) begin
      r_cnt      <= CNT_LOAD;
      r_op_wr    <= write;
      r_bank_ins <= instruction;
      r_idx      <= address[AW-1:0];
      r_data     <= dataIn;
    end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Arrays are not reset; an aborted write never reaches the commit edge.
  always_ff @(posedge clk) begin
    if (w_commit_wr) begin
      if (r_bank_ins) begin
        r_mem_ins[r_idx] <= r_data;
      end else begin
        r_mem_dat[r_idx] <= r_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataOut <= '0;
    end else if (w_commit_rd) begin
      dataOut <= r_bank_ins ? r_mem_ins[r_idx] : r_mem_dat[r_idx];
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: directed scenarios plus randomized traffic
// compared against a per-bank array model with Done timing derived from LATENCY.
module tb_main_memory;

  localparam int LAT = 3;

  logic        clk;
  logic        reset;
  logic [12:0] address;
  logic [12:0] dataIn;
  logic [12:0] dataOut;
  logic        write;
  logic        read;
  logic        instruction;
  logic        Done;

  int n_vec;
  int n_err;

  logic [12:0] m_ins [256];
  logic [12:0] m_dat [256];
  bit          v_ins [256];
  bit          v_dat [256];
  logic [12:0] exp_out;
  bit          exp_valid;

  main_memory #(.LATENCY(LAT), .DEPTH(256)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .dataIn      (dataIn),
    .dataOut     (dataOut),
    .write       (write),
    .read        (read),
    .instruction (instruction),
    .Done        (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, scramble inputs after acceptance, optionally keep requesting
  // during BUSY/DONE, and check Done occurs exactly once, LAT cycles after acceptance.
  task automatic do_op(input bit wr, input bit rd, input bit ins, input logic [7:0] idx,
                       input logic [12:0] d, input bit noise, input string tag);
    @(negedge clk);
    address     = {5'($urandom), idx};
    dataIn      = d;
    write       = wr;
    read        = rd;
    instruction = ins;
    @(posedge clk);
    #1;
    address     = 13'($urandom);
    dataIn      = 13'($urandom);
    instruction = 1'($urandom);
    write       = noise ? 1'($urandom) : 1'b0;
    read        = noise;
    if (wr) begin
      if (ins) begin m_ins[idx] = d; v_ins[idx] = 1'b1; end
      else     begin m_dat[idx] = d; v_dat[idx] = 1'b1; end
    end else if (rd) begin
      exp_out   = ins ? m_ins[idx] : m_dat[idx];
      exp_valid = ins ? v_ins[idx] : v_dat[idx];
    end
    for (int k = 1; k <= 2 * LAT + 3; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (Done !== (k == LAT)) begin
        n_err++;
        $display("FAIL %s done_timing cycle=%0d got=%b expected=%b", tag, k, Done, (k == LAT));
      end
      if (k == LAT + 1) begin
        write = 1'b0;
        read  = 1'b0;
      end
    end
    if (exp_valid) begin
      n_vec++;
      if (dataOut !== exp_out) begin
        n_err++;
        $display("FAIL %s dataOut got=%h expected=%h", tag, dataOut, exp_out);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; write = 1'b0; read = 1'b0; instruction = 1'b0;
    address = '0; dataIn = '0;
    #2;
    n_vec++;
    if (Done !== 1'b0 || dataOut !== 13'h0) begin
      n_err++;
      $display("FAIL reset_async Done=%b dataOut=%h expected 0/0000", Done, dataOut);
    end
    write = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    write = 1'b0;
    reset = 1'b1;
    exp_out = 13'h0; exp_valid = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (Done !== 1'b0 || dataOut !== 13'h0) begin
        n_err++;
        $display("FAIL reset_release cycle=%0d Done=%b dataOut=%h expected 0/0000", k, Done, dataOut);
      end
    end
  endtask

  task automatic test_write_read();
    do_op(1'b1, 1'b0, 1'b0, 8'd0, 13'h10F0, 1'b0, "write_data0");
    do_op(1'b0, 1'b1, 1'b0, 8'd0, 13'h0000, 1'b0, "read_data0");
    repeat (4) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (dataOut !== 13'h10F0) begin
        n_err++;
        $display("FAIL read_hold got=%h expected=10f0", dataOut);
      end
    end
  endtask

  task automatic test_bank_isolation();
    do_op(1'b1, 1'b0, 1'b1, 8'd0, 13'h0ABC, 1'b0, "write_ins0");
    do_op(1'b0, 1'b1, 1'b1, 8'd0, 13'h0000, 1'b0, "read_ins0");
    do_op(1'b0, 1'b1, 1'b0, 8'd0, 13'h0000, 1'b0, "read_data0_iso");
  endtask

  task automatic test_priority_busy_ignore();
    do_op(1'b1, 1'b1, 1'b0, 8'd1, 13'h1FFF, 1'b1, "rw_priority");
    do_op(1'b0, 1'b1, 1'b0, 8'd1, 13'h0000, 1'b0, "read_after_priority");
    do_op(1'b0, 1'b1, 1'b1, 8'd0, 13'h0000, 1'b1, "read_with_noise");
  endtask

  task automatic test_reset_abort();
    do_op(1'b1, 1'b0, 1'b0, 8'd5, 13'h0123, 1'b0, "prewrite_addr5");
    @(negedge clk);
    address = 13'd5; dataIn = 13'h0555; instruction = 1'b0; write = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    exp_out = 13'h0; exp_valid = 1'b1;
    n_vec++;
    if (Done !== 1'b0 || dataOut !== 13'h0) begin
      n_err++;
      $display("FAIL abort_async Done=%b dataOut=%h expected 0/0000", Done, dataOut);
    end
    repeat (2) @(negedge clk);
    write = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 2 * LAT + 2; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (Done !== 1'b0) begin
        n_err++;
        $display("FAIL abort_no_done cycle=%0d got=%b expected=0", k, Done);
      end
    end
    do_op(1'b0, 1'b1, 1'b0, 8'd5, 13'h0000, 1'b0, "read_after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      bit          wr, rd, ins, nz;
      logic [7:0]  idx;
      logic [12:0] d;
      wr  = 1'($urandom);
      rd  = wr ? 1'($urandom) : 1'b1;
      ins = 1'($urandom);
      nz  = ($urandom_range(0, 3) == 0);
      idx = 8'($urandom_range(0, 15));
      d   = 13'($urandom);
      do_op(wr, rd, ins, idx, d, nz, "random");
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_valid = 1'b0;
    exp_out = '0;
    for (int i = 0; i < 256; i++) begin
      v_ins[i] = 1'b0;
      v_dat[i] = 1'b0;
      m_ins[i] = '0;
      m_dat[i] = '0;
    end
    test_reset();
    test_write_read();
    test_bank_isolation();
    test_priority_busy_ignore();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
